// File: rtl/operand_stage_if.sv
// Handshake and writeback bundle between decode, the operand stage and the ALU.
// The slave modport is the operand stage; master is the surrounding environment.
interface operand_stage_if #(
  parameter int W   = 8,
  parameter int A   = 4,
  parameter int Ops = 4
);
  logic           InValid;
  logic           InReady;
  logic [A-1:0]   RaddrA;
  logic [A-1:0]   RaddrB;
  logic [Ops-1:0] OpIn;
  logic [A-1:0]   DestIn;
  logic           WenIn;

  logic           OutValid;
  logic           OutReady;
  logic [W-1:0]   InputA;
  logic [W-1:0]   InputB;
  logic [Ops-1:0] OP;
  logic [A-1:0]   DestOut;
  logic           WenOut;

  logic           WbEn;
  logic [A-1:0]   WbAddr;
  logic [W-1:0]   WbData;

  modport master (
    output InValid, RaddrA, RaddrB, OpIn, DestIn, WenIn, OutReady, WbEn, WbAddr, WbData,
    input  InReady, OutValid, InputA, InputB, OP, DestOut, WenOut
  );

  modport slave (
    input  InValid, RaddrA, RaddrB, OpIn, DestIn, WenIn, OutReady, WbEn, WbAddr, WbData,
    output InReady, OutValid, InputA, InputB, OP, DestOut, WenOut
  );
endinterface

// File: rtl/operand_stage.sv
// Operand-fetch stage: register file, pending scoreboard and registered ALU operands.
// Optional macro REG_BYPASS_EN forwards same-cycle writeback data into the fetch.
module operand_stage #(
  parameter int W   = 8,
  parameter int A   = 4,
  parameter int Ops = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  operand_stage_if.slave  bus
);
  localparam int N = 1 << A;

  logic [W-1:0]   r_regfile [N];
  logic [N-1:0]   r_pending;
  logic           r_out_valid;
  logic [W-1:0]   r_input_a;
  logic [W-1:0]   r_input_b;
  logic [Ops-1:0] r_op;
  logic [A-1:0]   r_dest;
  logic           r_wen;

  logic [N-1:0]   w_wb_hit;
  logic [N-1:0]   w_set_hit;
  logic [N-1:0]   w_pend_view;
  logic [W-1:0]   w_src_a;
  logic [W-1:0]   w_src_b;
  logic           w_hazard;
  logic           w_in_ready;
  logic           w_accept;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
      assign w_wb_hit[gi]  = bus.WbEn && (bus.WbAddr == A'(gi));
      assign w_set_hit[gi] = w_accept && bus.WenIn && (bus.DestIn == A'(gi));
    end
  endgenerate

`ifdef REG_BYPASS_EN
  // A register being written back this cycle is already resolved for the hazard check.
  assign w_pend_view = r_pending & ~w_wb_hit;
  assign w_src_a = (bus.WbEn && (bus.WbAddr == bus.RaddrA)) ? bus.WbData : r_regfile[bus.RaddrA];
  assign w_src_b = (bus.WbEn && (bus.WbAddr == bus.RaddrB)) ? bus.WbData : r_regfile[bus.RaddrB];
`else
  assign w_pend_view = r_pending;
  assign w_src_a = r_regfile[bus.RaddrA];
  assign w_src_b = r_regfile[bus.RaddrB];
`endif

  assign w_hazard   = w_pend_view[bus.RaddrA] | w_pend_view[bus.RaddrB]
                    | (bus.WenIn & w_pend_view[bus.DestIn]);
  assign w_in_ready = (!r_out_valid || bus.OutReady) && !w_hazard;
  assign w_accept   = bus.InValid && w_in_ready;

  // Set after clear: a same-cycle accept to the written-back register stays pending.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pending <= '0;
      for (int i = 0; i < N; i++) r_regfile[i] <= '0;
    end else begin
      r_pending <= (r_pending & ~w_wb_hit) | w_set_hit;
      for (int i = 0; i < N; i++) begin
        if (w_wb_hit[i]) r_regfile[i] <= bus.WbData;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_input_a   <= '0;
      r_input_b   <= '0;
      r_op        <= '0;
      r_dest      <= '0;
      r_wen       <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_input_a   <= w_src_a;
      r_input_b   <= w_src_b;
      r_op        <= bus.OpIn;
      r_dest      <= bus.DestIn;
      r_wen       <= bus.WenIn;
    end else if (r_out_valid && bus.OutReady) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.InReady  = w_in_ready;
  assign bus.OutValid = r_out_valid;
  assign bus.InputA   = r_input_a;
  assign bus.InputB   = r_input_b;
  assign bus.OP       = r_op;
  assign bus.DestOut  = r_dest;
  assign bus.WenOut   = r_wen;
endmodule

// File: doc/operand_stage.md
# operand_stage

Operand-fetch stage directly upstream of the combinational ALU. It holds the architectural register file and a per-register pending scoreboard. It accepts decoded instructions over a valid/ready handshake and presents registered InputA/InputB/OP to the ALU, together with the destination tag. It takes the ALU result back through a writeback port.

## Interface
- W, 8: data width; matches ALU W
- A, 4: register address width; register file holds 2^A entries
- Ops, 4: opcode width; matches ALU Ops
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- InValid  in  1  decoded instruction present
- InReady  out  1  stage accepts instruction this cycle
- RaddrA  in  A  source register for InputA
- RaddrB  in  A  source register for InputB
- OpIn  in  Ops  ALU opcode
- DestIn  in  A  destination register
- WenIn  in  1  instruction writes DestIn
- OutValid  out  1  InputA/InputB/OP/DestOut/WenOut are valid
- OutReady  in  1  downstream consumes current output
- InputA  out  W  registered operand A
- InputB  out  W  registered operand B
- OP  out  Ops  registered opcode
- DestOut  out  A  registered destination
- WenOut  out  1  registered write flag
- WbEn  in  1  writeback strobe
- WbAddr  in  A  writeback register
- WbData  in  W  writeback data (ALU Out)

## Operation
- Storage: 2^A x W register file; pending[2^A] scoreboard; one output register set.
- Register reads are combinational and are captured into InputA/InputB only on accept.
- Hazard = pending[RaddrA] | pending[RaddrB] | (WenIn & pending[DestIn]). This covers RAW and WAW.
- InReady = (!OutValid | OutReady) & !Hazard. InReady may depend combinationally on the address inputs.
- Accept = InValid & InReady. On accept:
  - load InputA, InputB, OP, DestOut, WenOut;
  - OutValid <= 1;
  - if WenIn, pending[DestIn] <= 1.
- OutValid & OutReady without accept: OutValid <= 0. All output values hold their last contents.
- Writeback (WbEn):
  - regfile[WbAddr] <= WbData;
  - pending[WbAddr] <= 0.
  - Writeback to a non-pending register is legal: data is written and pending stays 0.
- Same-cycle set and clear of the same register (accept with WenIn, DestIn == WbAddr): set wins, so pending = 1.
- Register 0 is an ordinary register; it is not hard-wired to zero.
- While OutValid & !OutReady, all outputs stay stable.

## Timing
- Reset, asynchronous: all regfile entries 0, pending all 0, OutValid 0, InputA/InputB 0, OP 0, DestOut 0, WenOut 0.
- Reset asserted mid-operation discards the in-flight output and all pending bits immediately.
- Latency: accept at edge N gives OutValid = 1 and the new operands during cycle N+1.
- Throughput: one instruction per cycle while OutReady = 1 and no hazard.
- Writeback at edge N: data is readable, and pending is cleared, from cycle N+1.
- Hazard resolution without bypass: an instruction stalled on register X is accepted no earlier than the cycle after WbEn for X.

## Configuration
- REG_BYPASS_EN defined:
  - In a cycle with WbEn, pending[WbAddr] is treated as 0 for the hazard check.
  - Any source equal to WbAddr captures WbData instead of the regfile value.
  - A stalled instruction is accepted in the same cycle as its writeback.
- REG_BYPASS_EN undefined:
  - No forwarding.
  - Hazard uses the registered pending bits only, giving one extra stall cycle versus bypass.

## Test plan
- Reset, then accept RaddrA=3, RaddrB=7 -> next cycle OutValid=1, InputA=0x00, InputB=0x00.
- Writeback r2=0x5A and r5=0x11, then accept RaddrA=2, RaddrB=5, OpIn=ADD -> next cycle InputA=0x5A, InputB=0x11, OP=ADD.
- Backpressure: OutValid=1 with OutReady=0 for 3 cycles -> InReady=0 and outputs unchanged. Raise OutReady -> the pending input is accepted that cycle.
- RAW: accept DestIn=4, WenIn=1, then present RaddrA=4 -> InReady=0. Drive WbEn, WbAddr=4, WbData=0x3C:
  - with REG_BYPASS_EN, accepted in the same cycle with InputA=0x3C;
  - without it, accepted one cycle later with InputA=0x3C.
- Same-cycle set and clear: accept DestIn=6, WenIn=1 while WbEn, WbAddr=6 -> pending[6]=1, so a subsequent read of r6 stalls.
- Reset mid-op: assert Reset with OutValid=1 and pending[4]=1 -> OutValid=0 immediately. After release, a read of r4 is accepted at once and returns 0x00.
